// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: supported LFSR orders, seed, and the unrolled 10-bit advance.
// The step function works on a MAX_N-wide state; callers use only the low N bits.
package prbs_pkg;

  localparam int DATA_W = 10;
  localparam int MAX_N  = 31;
  localparam int STEP_W = MAX_N + DATA_W;

  localparam logic [MAX_N-1:0] PRBS_SEED = '1;

  // Lower polynomial exponent for each supported order; 0 marks an unsupported order.
  function automatic int prbs_tap(input int n);
    case (n)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      20:      return 3;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

  // Returns {next_state, word}; the first generated bit lands in word[DATA_W-1].
  function automatic logic [STEP_W-1:0] prbs_step10(input logic [MAX_N-1:0] state,
                                                    input int n);
    logic [MAX_N-1:0]  s;
    logic [DATA_W-1:0] w;
    logic              fb;
    logic [4:0]        msb;
    logic [4:0]        tp;
    msb = 5'(n - 1);
    tp  = 5'(prbs_tap(n) - 1);
    s   = state;
    w   = '0;
    fb  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w  = {w[DATA_W-2:0], s[msb]};
      fb = s[msb] ^ s[tp];
      s  = {s[MAX_N-2:0], fb};
    end
    return {s, w};
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR advancing ten bit-steps per enabled cycle, with frame reseed and
// an all-zero lock-up guard.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int PRBS_LENGTH = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_advance,
  input  logic              i_reseed,
  output logic [DATA_W-1:0] o_word
);

  if (prbs_tap(PRBS_LENGTH) == 0) begin : g_bad_order
    $error("prbs_lfsr: unsupported PRBS_LENGTH");
  end

  localparam logic [PRBS_LENGTH-1:0] SEED = PRBS_SEED[PRBS_LENGTH-1:0];

  logic [PRBS_LENGTH-1:0] r_state;
  logic [PRBS_LENGTH-1:0] w_cur;
  logic [PRBS_LENGTH-1:0] w_next;
  logic [STEP_W-1:0]      w_step;

  // A zero state is treated as the seed, so the word produced on the recovery edge
  // is already frame word 0 rather than a stuck zero.
  assign w_cur  = (r_state == '0) ? SEED : r_state;
  assign w_step = prbs_step10(MAX_N'(w_cur), PRBS_LENGTH);
  assign w_next = w_step[DATA_W +: PRBS_LENGTH];
  assign o_word = w_step[DATA_W-1:0];

  if (PRBS_LENGTH < MAX_N) begin : g_hi
    logic [MAX_N-PRBS_LENGTH-1:0] w_unused_hi;
    assign w_unused_hi = w_step[STEP_W-1:DATA_W+PRBS_LENGTH];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_advance) begin
      r_state <= i_reseed ? SEED : w_next;
    end else if (r_state == '0) begin
      r_state <= SEED;
    end
  end

endmodule

// File: rtl/data_gen.sv
// Framed PRBS data source: one 10-bit word per enabled clock, PRBS restarted each frame,
// output forced to zero while idle.
module data_gen
  import prbs_pkg::*;
#(
  parameter int PRBS_LENGTH = 20,
  parameter int FRAME_WORDS = 1024,
  parameter int DATA_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_enable,
  output logic [DATA_WIDTH-1:0] data_out
);

  if (FRAME_WORDS < 2) begin : g_bad_frame
    $error("data_gen: FRAME_WORDS must be at least 2");
  end
  if (DATA_WIDTH != DATA_W) begin : g_bad_width
    $error("data_gen: DATA_WIDTH must be 10");
  end

  localparam int              CNT_W     = $clog2(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_frame_end;
  logic [DATA_W-1:0]     w_word;

  // Assertion is immediate; release reaches the datapath two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_frame_end = (r_word_cnt == LAST_WORD);

  prbs_lfsr #(
    .PRBS_LENGTH(PRBS_LENGTH)
  ) u_lfsr (
    .i_clk    (clk),
    .i_rst_n  (w_rst_n),
    .i_advance(send_enable),
    .i_reseed (w_frame_end),
    .o_word   (w_word)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_word_cnt <= '0;
      r_data_out <= '0;
    end else if (send_enable) begin
      r_word_cnt <= w_frame_end ? '0 : r_word_cnt + CNT_W'(1);
      r_data_out <= w_word;
    end else begin
      r_data_out <= '0;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_data_gen.sv
// Directed bench for data_gen: N=20 instance with 8-word frames, plus an N=7 instance
// for period and lock-up checks.
module tb_data_gen;

  logic       clk;
  logic       rst;
  logic       send_enable;
  logic [9:0] data_out;
  logic       rst7;
  logic       en7;
  logic [9:0] data_out7;

  int n_vec;
  int n_err;

  logic [9:0] exp3 [3] = '{10'h3FF, 10'h3FF, 10'h071};
  logic [9:0] frame0 [8];
  logic [9:0] words7 [127];
  logic       bits7 [1270];
  int         mism;
  int         ones;
  int         zero_hits;

  data_gen #(
    .PRBS_LENGTH(20),
    .FRAME_WORDS(8),
    .DATA_WIDTH (10)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .send_enable(send_enable),
    .data_out   (data_out)
  );

  data_gen #(
    .PRBS_LENGTH(7),
    .FRAME_WORDS(4096),
    .DATA_WIDTH (10)
  ) u_dut7 (
    .clk        (clk),
    .rst        (rst7),
    .send_enable(en7),
    .data_out   (data_out7)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b0;
    send_enable = 1'b0;
    rst7        = 1'b0;
    en7         = 1'b0;
    mism        = 0;
    ones        = 0;
    zero_hits   = 0;

    // 1: reset, idle, first words
    #50;
    check("reset_out", 32'(data_out), 32'h0);
    check("reset_out7", 32'(data_out7), 32'h0);
    #50;
    rst  = 1'b1;
    rst7 = 1'b1;
    #40;
    check("idle_out", 32'(data_out), 32'h0);
    #10;
    send_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      frame0[i] = data_out;
    end
    for (int i = 0; i < 3; i++) check($sformatf("frame0_w%0d", i), 32'(frame0[i]), 32'(exp3[i]));

    // 2: second frame identical to the first
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 3) check($sformatf("frame1_w%0d", i), 32'(data_out), 32'(exp3[i]));
      else       check($sformatf("frame1_w%0d", i), 32'(data_out), 32'(frame0[i]));
    end

    // 3: pause after word 1
    step();
    check("pause_w0", 32'(data_out), 32'h3FF);
    step();
    check("pause_w1", 32'(data_out), 32'h3FF);
    send_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pause_idle%0d", i), 32'(data_out), 32'h0);
    end
    send_enable = 1'b1;
    step();
    check("resume_w2", 32'(data_out), 32'h071);

    // 4: asynchronous reset mid-frame
    step();
    check("resume_w3", 32'(data_out), 32'(frame0[3]));
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_out", 32'(data_out), 32'h0);
    step();
    check("in_rst_out", 32'(data_out), 32'h0);
    #3;
    rst         = 1'b1;
    send_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), 32'(data_out), 32'h0);
    end
    send_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_w%0d", i), 32'(data_out), 32'(exp3[i]));
    end

    // 6: forced all-zero state recovers as seed
    force u_dut.u_lfsr.r_state = '0;
    step();
    check("zero_guard_w", 32'(data_out), 32'h3FF);
    release u_dut.u_lfsr.r_state;
    step();
    check("zero_guard_next", 32'(data_out), 32'h3FF);
    send_enable = 1'b0;

    // 5: N=7 period and lock-up
    en7 = 1'b1;
    for (int k = 0; k < 127; k++) begin
      step();
      words7[k] = data_out7;
      for (int j = 0; j < 10; j++) bits7[10*k + j] = data_out7[9-j];
      if (u_dut7.u_lfsr.r_state == '0) zero_hits++;
    end
    en7 = 1'b0;
    check("n7_w0", 32'(words7[0]), 32'h3F8);
    check("n7_w1", 32'(words7[1]), 32'h041);
    for (int i = 0; i + 127 < 1270; i++) if (bits7[i] !== bits7[i+127]) mism++;
    check("n7_period127", 32'(mism), 32'h0);
    for (int i = 0; i < 127; i++) if (bits7[i] === 1'b1) ones++;
    check("n7_ones", 32'(ones), 32'd64);
    check("n7_no_zero_state", 32'(zero_hits), 32'h0);
    check("n7_state_wrap", 32'(u_dut7.u_lfsr.r_state), 32'h7F);
    step();
    check("n7_idle", 32'(data_out7), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
